// File: rtl/lab7soc_key_in.sv
// Avalon-MM input port for board keys/switches: synchronize, debounce, edge capture
// and maskable level interrupt, laid out like the standard PIO register map.
module lab7soc_key_in #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] sync_p0, sync_p1;
    logic [WIDTH-1:0] deb_p2, deb_d_p3;
    logic [CNT_W-1:0] cnt_p2 [WIDTH];
    logic [WIDTH-1:0] edgecap, irqmask;
    logic [WIDTH-1:0] rise, fall, edge_det, clr_mask;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;
    assign clr_mask     = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Stage p0/p1: two-flop synchronizer on the raw pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= RESET_LEVEL;
            sync_p1 <= RESET_LEVEL;
        end else begin
            sync_p0 <= in_port;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: per-bit debounce, a new level must persist DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_p2 <= RESET_LEVEL;
            for (int i = 0; i < WIDTH; i++) cnt_p2[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_p1[i] == deb_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_LAST) begin
                    deb_p2[i] <= sync_p1[i];
                    cnt_p2[i] <= '0;
                end else begin
                    cnt_p2[i] <= sat_inc(cnt_p2[i]);
                end
            end
        end
    end

    always_comb begin
        rise = deb_p2 & ~deb_d_p3;
        fall = ~deb_p2 & deb_d_p3;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    // Stage p3: edge capture and control registers; a new edge beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d_p3 <= RESET_LEVEL;
            edgecap  <= '0;
            irqmask  <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            deb_d_p3 <= deb_p2;
            edgecap  <= (edgecap & ~clr_mask) | edge_det;
            if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
            irq      <= |(edgecap & irqmask);
            readdata <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = deb_p2;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecap;
            default: rd_mux = '0;
        endcase
    end

endmodule

// File: tb/tb_lab7soc_key_in.sv
// Bench for lab7soc_key_in: register vectors from a table, then multi-cycle key sequences
// checked through a read scoreboard on a falling-edge (EDGE_TYPE 1) and an any-edge instance.
module tb_lab7soc_key_in;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    typedef struct {
        logic        sel;
        logic [31:0] exp;
        string       nm;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata, readdata2;
    logic        irq, irq2;

    logic        rd_issue = 1'b0;
    logic        rd_seen  = 1'b0;
    sb_t         sb [$];
    sb_t         pop_ent;
    vec_t        vt [12];
    int          total = 0;
    int          bad   = 0;

    lab7soc_key_in #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    lab7soc_key_in #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata2), .irq(irq2)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Readdata is registered: a read issued before edge k is checked at the negedge after k
    always @(posedge clk) rd_seen <= rd_issue;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                pop_ent = sb.pop_front();
                check(pop_ent.nm, pop_ent.sel ? readdata2 : readdata, pop_ent.exp);
            end
        end
    end

    task automatic cyc_bus(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                           input logic [31:0] e, input string nm, input logic sel);
        sb_t ent;
        address    = a;
        chipselect = 1'b1;
        write_n    = ~wr;
        writedata  = wd;
        rd_issue   = 1'b1;
        ent.sel = sel;
        ent.exp = e;
        ent.nm  = nm;
        sb.push_back(ent);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_issue   = 1'b0;
    endtask

    task automatic cyc_write(input logic [1:0] a, input logic [31:0] wd);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = wd;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic cyc_idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 4'hF;

        vt[0]  = '{1'b1, 2'd2, 32'h0000000A, 32'h0, "mask_wr0"};
        vt[1]  = '{1'b0, 2'd2, 32'h0,        32'hA, "mask_rd"};
        vt[2]  = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'hA, "mask_wr_old"};
        vt[3]  = '{1'b0, 2'd2, 32'h0,        32'hF, "mask_upper"};
        vt[4]  = '{1'b1, 2'd0, 32'h0,        32'hF, "data_wr"};
        vt[5]  = '{1'b0, 2'd0, 32'h0,        32'hF, "data_ro"};
        vt[6]  = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h0, "rsvd_wr"};
        vt[7]  = '{1'b0, 2'd1, 32'h0,        32'h0, "rsvd_rd"};
        vt[8]  = '{1'b1, 2'd3, 32'hF,        32'h0, "ecap_wr"};
        vt[9]  = '{1'b0, 2'd3, 32'h0,        32'h0, "ecap_rd"};
        vt[10] = '{1'b1, 2'd2, 32'h0,        32'hF, "mask_wr_clr"};
        vt[11] = '{1'b0, 2'd2, 32'h0,        32'h0, "mask_rd0"};

        cyc_idle(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_readdata2", readdata2, 32'h0);
        check("rst_irq2", {31'd0, irq2}, 32'h0);
        reset_n = 1'b1;
        cyc_idle(3);

        for (int i = 0; i < 12; i++)
            cyc_bus(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].nm, 1'b0);
        check("tbl_irq", {31'd0, irq}, 32'h0);

        // Short glitch on key 0 must never reach DATA
        in_port = 4'hE;
        for (int n = 0; n < 5; n++) cyc_bus(1'b0, 2'd0, 32'h0, 32'hF, "glitch_low", 1'b0);
        in_port = 4'hF;
        for (int n = 0; n < 15; n++) cyc_bus(1'b0, 2'd0, 32'h0, 32'hF, "glitch_after", 1'b0);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h0, "glitch_ecap", 1'b0);
        check("glitch_irq", {31'd0, irq}, 32'h0);

        // Held press: DATA flips at edge 10 after the pin change, seen on the read after it
        in_port = 4'hE;
        for (int n = 0; n < 20; n++)
            cyc_bus(1'b0, 2'd0, 32'h0, (n >= 10) ? 32'hE : 32'hF, "hold_data", 1'b0);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h1, "hold_ecap", 1'b0);
        check("hold_irq", {31'd0, irq}, 32'h0);

        // Interrupt path
        in_port = 4'hF;
        cyc_idle(12);
        cyc_write(2'd3, 32'hF);
        cyc_write(2'd2, 32'h1);
        in_port = 4'hE;
        for (int n = 0; n < 16; n++) begin
            check("irq_rise", {31'd0, irq}, (n >= 12) ? 32'h1 : 32'h0);
            cyc_bus(1'b0, 2'd3, 32'h0, (n >= 11) ? 32'h1 : 32'h0, "ecap_rise", 1'b0);
        end
        cyc_write(2'd3, 32'h1);
        check("irq_hold", {31'd0, irq}, 32'h1);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h0, "ecap_w1c", 1'b0);
        check("irq_fall", {31'd0, irq}, 32'h0);

        // Masking and selective W1C
        cyc_write(2'd2, 32'h0);
        in_port = 4'h8;
        cyc_idle(14);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h6, "mask_ecap", 1'b0);
        check("masked_irq", {31'd0, irq}, 32'h0);
        cyc_write(2'd3, 32'h2);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h4, "w1c_sel", 1'b0);
        cyc_write(2'd2, 32'h4);
        check("irq_mask_lag", {31'd0, irq}, 32'h0);
        cyc_idle(1);
        check("irq_unmask", {31'd0, irq}, 32'h1);

        // Set/clear collision on bit 3: the clear lands on the capture edge
        in_port = 4'h0;
        cyc_idle(10);
        cyc_write(2'd3, 32'h8);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'hC, "collide_set", 1'b0);
        cyc_write(2'd3, 32'h8);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h4, "collide_clr", 1'b0);

        // Any-edge instance
        in_port = 4'hF;
        cyc_idle(12);
        cyc_write(2'd3, 32'hF);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h0, "any_clr", 1'b1);
        in_port = 4'hE;
        cyc_idle(12);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h1, "any_press", 1'b1);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h1, "fall_press", 1'b0);
        cyc_write(2'd3, 32'h1);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h0, "any_mid", 1'b1);
        in_port = 4'hF;
        cyc_idle(12);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h1, "any_release", 1'b1);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h0, "fall_no_rise", 1'b0);
        cyc_bus(1'b0, 2'd1, 32'h0, 32'h0, "any_rsvd", 1'b1);
        cyc_bus(1'b0, 2'd0, 32'h0, 32'hF, "any_data_upper", 1'b1);

        // Reset mid-debounce
        in_port = 4'hD;
        cyc_idle(12);
        cyc_write(2'd2, 32'hF);
        in_port = 4'hF;
        cyc_idle(12);
        address = 2'd0;
        in_port = 4'hE;
        cyc_idle(6);
        check("pre_rst_data", readdata, 32'hF);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        check("mid_rst_readdata2", readdata2, 32'h0);
        cyc_idle(3);
        reset_n = 1'b1;
        for (int n = 0; n < 14; n++)
            cyc_bus(1'b0, 2'd0, 32'h0, (n >= 10) ? 32'hE : 32'hF, "rst_data", 1'b0);
        cyc_bus(1'b0, 2'd3, 32'h0, 32'h1, "rst_ecap", 1'b0);
        cyc_bus(1'b0, 2'd2, 32'h0, 32'h0, "rst_mask", 1'b0);
        check("rst_irq_after", {31'd0, irq}, 32'h0);

        cyc_idle(2);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
